arch_reg_read_unit: RTL and testbench
=====================================

# arch_reg_read_unit

Slave side of the architectural-register read port (`ARCH_REG_READ_IF.slave`) inside `CPU`. It accepts a request for an architectural register index, translates it through the committed rename map (retirement RAT) to a physical tag, and wins a read slot on the physical register file (PRF) through a request/grant handshake. It then returns the committed value with a one-cycle `read_valid` pulse. The unit is used for post-`finish` register dumps and debug reads, and it never disturbs in-flight execution.

## Interface
- `ARCH_REG_NUM`, default 32: number of architectural registers; the index width is `$clog2(ARCH_REG_NUM)`.
- `PHYS_REG_NUM`, default 64: number of physical registers; the tag width is `$clog2(PHYS_REG_NUM)`.
- `REG_VAL_WIDTH`, default 32: register data width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock for the unit.
- `reset`, in, 1: synchronous, active-high reset.
- `rd_en`, in, 1: read request level, from `ARCH_REG_READ_IF`.
- `read_red_addr_req`, in, idx: architectural register index.
- `read_valid`, out, 1: one-cycle pulse, response valid.
- `read_value`, out, `REG_VAL_WIDTH`: response data; holds its value until the next response.
- `retire_busy`, in, 1: a commit is updating the retirement RAT or PRF this cycle.
- `rat_rd_addr`, out, idx: index into the retirement RAT (combinational read port).
- `rat_rd_tag`, in, tag: physical tag for `rat_rd_addr`, valid in the same cycle.
- `prf_rd_req`, out, 1: request for the shared PRF debug read slot.
- `prf_rd_addr`, out, tag: PRF address; stable while `prf_rd_req` is high.
- `prf_rd_gnt`, in, 1: grant, sampled at the clock edge.
- `prf_rd_data`, in, `REG_VAL_WIDTH`: PRF data, valid exactly one cycle after the grant.

## Operation
The FSM has the states IDLE, LOOKUP, REQ, DATA, RESP and DROP. Transitions:
- **IDLE**: if `rd_en`=1, latch `read_red_addr_req` into `addr_q`.
  - If `addr_q` is 0 (x0), go to RESP with value 0. No RAT or PRF access is made.
  - Otherwise go to LOOKUP.
- **LOOKUP**: drive `rat_rd_addr`=`addr_q`.
  - If `retire_busy`=1, stay in LOOKUP so the unit reads a consistent committed snapshot.
  - Otherwise register `rat_rd_tag` into `tag_q` and go to REQ.
- **REQ**: drive `prf_rd_req`=1 and `prf_rd_addr`=`tag_q`.
  - On `prf_rd_gnt`=1, drop the request in the next cycle and go to DATA.
  - Hold the request indefinitely without a grant (subject to the Configuration watchdog).
- **DATA**: capture `prf_rd_data` into `read_value`, then go to RESP.
- **RESP**: `read_valid`=1 for exactly this cycle, then go to DROP.
- **DROP**: wait for `rd_en`=0, then go to IDLE. This prevents a second issue from a requester that holds `rd_en` for one cycle after seeing `read_valid`.

Rules and boundary conditions:
- An index of `ARCH_REG_NUM` or above cannot occur at the default widths. For a non-power-of-two `ARCH_REG_NUM`, an out-of-range index is answered with value 0 through the x0 path.
- Changes to `read_red_addr_req` after acceptance are ignored; the latched `addr_q` is used.
- If `rd_en` drops before RESP, the transaction still completes and pulses `read_valid`.

## Timing
Reset values: `read_valid`=0, `read_value`=0, `prf_rd_req`=0, `prf_rd_addr`=0, `rat_rd_addr`=0, state IDLE.

Latency:
- A request is accepted at edge T.
- x0 read: `read_valid` is high in cycle T+1.
- Non-x0 read with `retire_busy`=0 and the grant in the first REQ cycle: LOOKUP in T+1, REQ in T+2, DATA in T+3, `read_valid` high in T+4.
- Each `retire_busy` cycle and each ungranted REQ cycle adds exactly one cycle.

Throughput:
- Back-to-back requests with one idle `rd_en` cycle between them complete every 6 cycles (non-x0, no stalls).
- `prf_rd_req` is never high outside REQ.

Reset mid-operation:
- Reset in any state returns to IDLE on that edge and drops `prf_rd_req` at once.
- No `read_valid` pulse is emitted for the aborted request, and `read_value` becomes 0.
- A grant that arrives in the reset cycle is ignored.

## Configuration
Macro `ARCH_REG_READ_TIMEOUT_EN`.
- **Defined**: an 8-bit counter runs while the unit is in REQ and clears on entry to REQ.
  - When the counter reaches 255 without a grant, the unit drops `prf_rd_req` and goes to RESP with `read_value`=32'hDEADBEEF (truncated or zero-extended to `REG_VAL_WIDTH`).
  - A `$display("[CPU_DEBUG] ARCH_REG_READ timeout reg %0d")` message is printed under simulation.
- **Not defined**: there is no counter, and REQ waits for a grant forever.

## Test plan
- **x0 read**: `rd_en`=1 with addr 0. Expect `read_valid` one cycle later with `read_value`=0, and `prf_rd_req` never asserted.
- **Mapped read**: RAT maps arch 5 to phys 37, PRF[37]=32'h1234_5678, grant given immediately. Expect `prf_rd_addr`=37 and `read_valid` at T+4 with value 32'h1234_5678.
- **Stalls**:
  - `retire_busy` high for 3 cycles and the grant delayed 4 cycles. Expect `read_valid` at T+11 with the correct value.
  - `prf_rd_req` stays high continuously until the grant.
- **Dump sweep**: the requester holds `rd_en` one cycle after `read_valid` and reads indices 0–31 sequentially.
  - Expect exactly 32 `read_valid` pulses with no duplicate issue.
  - Values must match the committed RAT/PRF contents.
- **Reset mid-operation**: assert `reset` while in REQ. Expect `prf_rd_req`=0, no `read_valid`, and `read_value`=0 on the next cycle. A fresh request after reset completes normally.
- **Timeout** (with `ARCH_REG_READ_TIMEOUT_EN`): never grant. Expect `read_valid` with 32'hDEADBEEF 255 cycles after entering REQ. Without the macro, expect no response within 1000 cycles.

Source files
------------

// File: rtl/arch_reg_read_unit_if.sv
// arch_reg_read_unit_if: architectural register read request/response channel
interface arch_reg_read_unit_if #(
  parameter int ARCH_REG_NUM  = 32,
  parameter int REG_VAL_WIDTH = 32
);
  localparam int IW = ARCH_REG_NUM > 1 ? $clog2(ARCH_REG_NUM) : 1;
  logic                     rd_en;
  logic [IW-1:0]            read_red_addr_req;
  logic                     read_valid;
  logic [REG_VAL_WIDTH-1:0] read_value;
  modport master (output rd_en, read_red_addr_req, input read_valid, read_value);
  modport slave  (input rd_en, read_red_addr_req, output read_valid, read_value);
endinterface

// File: rtl/arch_reg_read_unit.sv
// arch_reg_read_unit: committed arch register read via retirement RAT and shared PRF slot
// Optional REQ watchdog enabled by defining ARCH_REG_READ_TIMEOUT_EN.
module arch_reg_read_unit #(
  parameter  int ARCH_REG_NUM  = 32,
  parameter  int PHYS_REG_NUM  = 64,
  parameter  int REG_VAL_WIDTH = 32,
  localparam int IW = ARCH_REG_NUM > 1 ? $clog2(ARCH_REG_NUM) : 1,
  localparam int TW = PHYS_REG_NUM > 1 ? $clog2(PHYS_REG_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  arch_reg_read_unit_if.slave      rd,
  input  logic                     retire_busy,
  output logic [IW-1:0]            rat_rd_addr,
  input  logic [TW-1:0]            rat_rd_tag,
  output logic                     prf_rd_req,
  output logic [TW-1:0]            prf_rd_addr,
  input  logic                     prf_rd_gnt,
  input  logic [REG_VAL_WIDTH-1:0] prf_rd_data
);
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, DATA, RESP, DROP} state_t;
  state_t st, nxt;
  logic [IW-1:0] addr_q;
  logic [TW-1:0] tag_q;
  logic [REG_VAL_WIDTH-1:0] value_q;
  logic zero_req, tmo, valid;
  // out-of-range indices (non-power-of-two maps) are answered like x0
  assign zero_req = rd.read_red_addr_req == '0 || {1'b0, rd.read_red_addr_req} >= (IW+1)'(ARCH_REG_NUM);
`ifdef ARCH_REG_READ_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = cnt == 8'd254;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= st == REQ ? cnt + 8'd1 : '0;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && st == REQ && !prf_rd_gnt && tmo) $display("[CPU_DEBUG] ARCH_REG_READ timeout reg %0d", addr_q);
`endif
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = rd.rd_en ? (zero_req ? RESP : LOOKUP) : IDLE;
      LOOKUP:  nxt = retire_busy ? LOOKUP : REQ;
      REQ:     nxt = prf_rd_gnt ? DATA : (tmo ? RESP : REQ);
      DATA:    nxt = RESP;
      RESP:    nxt = DROP;
      DROP:    nxt = rd.rd_en ? DROP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    prf_rd_req = st == REQ;
    valid = st == RESP;
  end
  always_ff @(posedge clk)
    if (reset) begin
      addr_q  <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      if (st == IDLE && rd.rd_en) addr_q <= rd.read_red_addr_req;
      if (st == IDLE && rd.rd_en && zero_req) value_q <= '0;
      if (st == LOOKUP && !retire_busy) tag_q <= rat_rd_tag;
      if (st == REQ && !prf_rd_gnt && tmo) value_q <= REG_VAL_WIDTH'(32'hDEADBEEF);
      if (st == DATA) value_q <= prf_rd_data;
    end
  assign rat_rd_addr   = addr_q;
  assign prf_rd_addr   = tag_q;
  assign rd.read_valid = valid;
  assign rd.read_value = value_q;
endmodule

// File: tb/tb_arch_reg_read_unit.sv
// tb_arch_reg_read_unit: scoreboard bench with RAT/PRF model and delayed-grant arbiter
module tb_arch_reg_read_unit;
  localparam int AN = 32, PN = 64, W = 32;
  logic clk = 0, reset = 1, retire_busy = 0, prf_rd_gnt = 0, prf_rd_req;
  logic [4:0] rat_rd_addr;
  logic [5:0] rat_rd_tag, prf_rd_addr, exp_tag = 0;
  logic [W-1:0] prf_rd_data;
  logic [5:0] rat [AN];
  logic [W-1:0] prf [PN];
  int tests = 0, fails = 0, cyc = 0, req_cyc = 0, gnt_delay = 0, req_total = 0, valid_cnt = 0;
  typedef struct {logic [W-1:0] val; int due;} exp_t;
  exp_t q[$];
  arch_reg_read_unit_if #(.ARCH_REG_NUM(AN), .REG_VAL_WIDTH(W)) rd ();
  arch_reg_read_unit #(.ARCH_REG_NUM(AN), .PHYS_REG_NUM(PN), .REG_VAL_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .rd(rd), .retire_busy(retire_busy),
    .rat_rd_addr(rat_rd_addr), .rat_rd_tag(rat_rd_tag),
    .prf_rd_req(prf_rd_req), .prf_rd_addr(prf_rd_addr),
    .prf_rd_gnt(prf_rd_gnt), .prf_rd_data(prf_rd_data)
  );
  always #5 clk = ~clk;
  assign rat_rd_tag = rat[rat_rd_addr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) prf_rd_data <= (prf_rd_req && prf_rd_gnt) ? prf[prf_rd_addr] : W'($urandom);
  // arbiter: grant after gnt_delay ungranted REQ cycles
  always @(negedge clk)
    if (prf_rd_req) begin
      chk("prf_addr", prf_rd_addr, exp_tag);
      prf_rd_gnt = req_cyc == gnt_delay;
      req_cyc++;
      req_total++;
    end else begin
      prf_rd_gnt = 0;
      req_cyc = 0;
    end
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rd.read_valid) begin
      valid_cnt++;
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("value", rd.read_value, e.val);
        chk("latency", cyc, e.due);
      end
    end
  end
  function automatic logic [W-1:0] expv(input logic [4:0] a);
    return a == 0 ? '0 : prf[rat[a]];
  endfunction
  // starts and ends on a negedge with the DUT idle
  task automatic do_read(input logic [4:0] a, input logic [W-1:0] v, input int lat, input bit hold);
    exp_t e;
    int n = 0;
    e.val = v;
    e.due = cyc + lat;
    q.push_back(e);
    exp_tag = rat[a];
    rd.rd_en = 1;
    rd.read_red_addr_req = a;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) rd.read_red_addr_req = 5'($urandom);
    end while (!rd.read_valid && n < 2000);
    if (!rd.read_valid) begin
      chk("response", 0, 1);
      q.delete();
    end
    if (hold) @(negedge clk);
    rd.rd_en = 0;
    @(negedge clk);
    if (!hold) @(negedge clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    int r0, n;
    for (int i = 0; i < AN; i++) rat[i] = 6'((i * 13 + 11) % PN);
    rat[5] = 6'd37;
    for (int i = 0; i < PN; i++) prf[i] = $urandom | 32'h1;
    prf[37] = 32'h1234_5678;
    rd.rd_en = 0;
    rd.read_red_addr_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rd.read_valid, 0);
    chk("rst_value", rd.read_value, 0);
    chk("rst_req", prf_rd_req, 0);
    chk("rst_prf_addr", prf_rd_addr, 0);
    chk("rst_rat_addr", rat_rd_addr, 0);
    reset = 0;
    @(negedge clk);
    r0 = req_total;
    do_read(0, 0, 1, 0);
    chk("x0_no_req", req_total - r0, 0);
    r0 = req_total;
    do_read(5, 32'h1234_5678, 4, 0);
    chk("mapped_req_cycles", req_total - r0, 1);
    repeat (5) @(negedge clk);
    chk("value_hold", rd.read_value, 32'h1234_5678);
    gnt_delay = 4;
    retire_busy = 1;
    r0 = req_total;
    fork
      do_read(9, expv(9), 11, 0);
      begin
        repeat (4) @(negedge clk);
        retire_busy = 0;
      end
    join
    chk("stall_req_cycles", req_total - r0, 5);
    gnt_delay = 0;
    r0 = valid_cnt;
    for (int i = 0; i < AN; i++) do_read(5'(i), expv(5'(i)), i == 0 ? 1 : 4, 1);
    repeat (10) @(negedge clk);
    chk("sweep_pulses", valid_cnt - r0, AN);
    gnt_delay = 2;
    exp_tag = rat[7];
    rd.rd_en = 1;
    rd.read_red_addr_req = 7;
    @(negedge clk);
    rd.rd_en = 0;
    n = 0;
    while (!prf_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_reached_req", prf_rd_req, 1);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_req", prf_rd_req, 0);
    chk("mid_rst_valid", rd.read_valid, 0);
    chk("mid_rst_value", rd.read_value, 0);
    reset = 0;
    repeat (10) @(negedge clk);
    gnt_delay = 0;
    do_read(5, 32'h1234_5678, 4, 0);
    gnt_delay = 100000;
`ifdef ARCH_REG_READ_TIMEOUT_EN
    do_read(3, 32'hDEADBEEF, 257, 0);
`else
    exp_tag = rat[3];
    rd.rd_en = 1;
    rd.read_red_addr_req = 3;
    @(negedge clk);
    rd.rd_en = 0;
    r0 = valid_cnt;
    repeat (1000) @(negedge clk);
    chk("no_timeout", valid_cnt - r0, 0);
    chk("req_held", prf_rd_req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
`endif
    gnt_delay = 0;
    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
